// File: rtl/alarm_sequencer_if.sv
// Keypad/sensor inputs and siren/light/status outputs of the alarm sequencer.
// The master drives the keypad and sensors; the slave is the sequencer.
interface alarm_sequencer_if;
   logic       arm_req;
   logic       disarm_req;
   logic       vp;
   logic       sm;
   logic       armed;
   logic       siren;
   logic       lights;
   logic       arm_fail;
   logic [2:0] state_o;
   logic [3:0] alarm_cnt;

   modport master (
      output arm_req, disarm_req, vp, sm,
      input  armed, siren, lights, arm_fail, state_o, alarm_cnt
   );

   modport slave (
      input  arm_req, disarm_req, vp, sm,
      output armed, siren, lights, arm_fail, state_o, alarm_cnt
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Armed/door-window/motion alarm sequencer: exit delay, entry delay, timed siren,
// then lights held until disarm. All outputs are registered from the next state.
module alarm_sequencer #(
   parameter int unsigned EXIT_DLY  = 16,
   parameter int unsigned ENTRY_DLY = 8,
   parameter int unsigned SIREN_LEN = 32,
   parameter int unsigned CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   alarm_sequencer_if.slave   bus
);

   localparam logic [2:0] S_DISARMED = 3'd0;
   localparam logic [2:0] S_EXIT     = 3'd1;
   localparam logic [2:0] S_ARMED    = 3'd2;
   localparam logic [2:0] S_ENTRY    = 3'd3;
   localparam logic [2:0] S_ALARM    = 3'd4;
   localparam logic [2:0] S_HOLD     = 3'd5;

   localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
   localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
   localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             fail_nxt;
   logic             armed_q, siren_q, lights_q, fail_q;
   logic [3:0]       alarm_cnt_q;

   always_comb begin
      nxt      = state;
      cnt_nxt  = cnt;
      fail_nxt = 1'b0;
      if (state != S_DISARMED && bus.disarm_req) begin
         nxt     = S_DISARMED;
         cnt_nxt = '0;
      end else begin
         case (state)
            S_DISARMED: begin
               // disarm_req masks arm_req entirely, including the refusal pulse
               if (bus.arm_req && !bus.disarm_req) begin
                  if (bus.vp) begin
                     fail_nxt = 1'b1;
                  end else begin
                     nxt     = S_EXIT;
                     cnt_nxt = EXIT_LD;
                  end
               end
            end
            S_EXIT: begin
               if (cnt == '0) nxt = S_ARMED;
               else           cnt_nxt = cnt - CNT_ONE;
            end
            S_ARMED: begin
               if (bus.sm) begin
                  nxt     = S_ALARM;
                  cnt_nxt = SIREN_LD;
               end else if (bus.vp) begin
                  nxt     = S_ENTRY;
                  cnt_nxt = ENTRY_LD;
               end
            end
            S_ENTRY: begin
               if (cnt == '0) begin
                  nxt     = S_ALARM;
                  cnt_nxt = SIREN_LD;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            S_ALARM: begin
               if (cnt == '0) nxt = S_HOLD;
               else           cnt_nxt = cnt - CNT_ONE;
            end
            S_HOLD: begin
               if (bus.sm || bus.vp) begin
                  nxt     = S_ALARM;
                  cnt_nxt = SIREN_LD;
               end
            end
            default: begin
               nxt     = S_DISARMED;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_DISARMED;
         cnt         <= '0;
         armed_q     <= 1'b0;
         siren_q     <= 1'b0;
         lights_q    <= 1'b0;
         fail_q      <= 1'b0;
         alarm_cnt_q <= '0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_nxt;
         armed_q  <= (nxt == S_ARMED) || (nxt == S_ENTRY) ||
                     (nxt == S_ALARM) || (nxt == S_HOLD);
         siren_q  <= (nxt == S_ALARM);
         lights_q <= (nxt == S_ALARM) || (nxt == S_HOLD);
         fail_q   <= fail_nxt;
         if (nxt == S_ALARM && state != S_ALARM && alarm_cnt_q != 4'hF)
            alarm_cnt_q <= alarm_cnt_q + 4'd1;
      end
   end

   assign bus.armed     = armed_q;
   assign bus.siren     = siren_q;
   assign bus.lights    = lights_q;
   assign bus.arm_fail  = fail_q;
   assign bus.state_o   = state;
   assign bus.alarm_cnt = alarm_cnt_q;

endmodule
